// File: rtl/minbd_port_allocator_if.sv
// Link, injection and eject signal bundle for the MinBD output-port allocator.
interface minbd_port_allocator_if #(
  parameter int unsigned FLIT_W = 11,
  parameter int unsigned CNT_W  = 16
);
  logic [FLIT_W-1:0] nty, sty, ety, wty;
  logic [FLIT_W-1:0] inj_flit;
  logic              inj_valid;
  logic              inj_ready;
  logic              ej_ready;
  logic [FLIT_W-1:0] nxt, sxt, ext, wxt;
  logic [FLIT_W-1:0] ej_flit;
  logic              ej_valid;
  logic [CNT_W-1:0]  defl_cnt;

  modport master (
    output nty, sty, ety, wty, inj_flit, inj_valid, ej_ready,
    input  inj_ready, nxt, sxt, ext, wxt, ej_flit, ej_valid, defl_cnt
  );

  modport slave (
    input  nty, sty, ety, wty, inj_flit, inj_valid, ej_ready,
    output inj_ready, nxt, sxt, ext, wxt, ej_flit, ej_valid, defl_cnt
  );
endinterface

// File: rtl/minbd_port_allocator.sv
// MinBD deflection-router port allocator: rotating-priority allocation, registered outputs.
// Optional golden-epoch priority is enabled by defining GOLDEN_PRIO_EN.
module minbd_port_allocator #(
  parameter int unsigned FLIT_W    = 11,
  parameter int unsigned EPOCH_LEN = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  minbd_port_allocator_if.slave bus
);

  localparam int unsigned VldBit = FLIT_W - 1;

  if (EPOCH_LEN < 1) begin : g_bad_epoch
    $error("EPOCH_LEN must be at least 1");
  end

`ifdef GOLDEN_PRIO_EN
  localparam int unsigned NumPass = 2;
  localparam int unsigned EpW     = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;
  logic [EpW-1:0] r_epoch_cnt;
  logic [6:0]     r_golden_id;
`else
  localparam int unsigned NumPass = 1;
`endif

  logic [FLIT_W-1:0] w_in [4];
  logic [FLIT_W-1:0] w_out [4];
  logic [FLIT_W-1:0] r_out [4];
  logic [FLIT_W-1:0] w_ej_flit, r_ej_flit;
  logic              w_ej_take, r_ej_valid;
  logic [2:0]        w_defl;
  logic              w_inj_ready;
  logic              w_any_valid;
  logic [1:0]        r_prio_ptr;
  logic [CNT_W-1:0]  r_defl_cnt, w_defl_cnt;
  logic [CNT_W:0]    w_defl_sum;

  assign w_in[0] = bus.nty;
  assign w_in[1] = bus.sty;
  assign w_in[2] = bus.ety;
  assign w_in[3] = bus.wty;

  assign w_any_valid = bus.nty[VldBit] | bus.sty[VldBit] | bus.ety[VldBit] | bus.wty[VldBit];

  function automatic logic [1:0] lowest_free(input logic [3:0] taken);
    logic [1:0] port;
    port = 2'd0;
    for (int j = 3; j >= 0; j--) begin
      if (!taken[j]) port = 2'(j);
    end
    return port;
  endfunction

  always_comb begin
    logic [3:0]        taken;
    logic [1:0]        idx;
    logic [1:0]        port;
    logic [FLIT_W-1:0] flit;
    logic              sel;
    logic              defl;
    taken       = 4'b0;
    idx         = 2'd0;
    port        = 2'd0;
    flit        = '0;
    sel         = 1'b0;
    defl        = 1'b0;
    w_ej_take   = 1'b0;
    w_ej_flit   = '0;
    w_defl      = 3'd0;
    w_inj_ready = 1'b0;
    for (int i = 0; i < 4; i++) w_out[i] = '0;

    // Golden build: pass 0 takes golden-id flits, pass 1 the rest, both in rotating order.
    for (int p = 0; p < int'(NumPass); p++) begin
      for (int k = 0; k < 4; k++) begin
        idx  = r_prio_ptr + 2'(k);
        flit = w_in[idx];
`ifdef GOLDEN_PRIO_EN
        sel  = ((flit[6:0] == r_golden_id) == (p == 0));
`else
        sel  = 1'b1;
`endif
        defl = 1'b0;
        if (flit[VldBit] && sel) begin
          if (flit[9]) begin
            if (bus.ej_ready && !w_ej_take) begin
              w_ej_take = 1'b1;
              w_ej_flit = flit;
            end else begin
              defl = 1'b1;
            end
          end else if (!taken[flit[8:7]]) begin
            taken[flit[8:7]] = 1'b1;
            w_out[flit[8:7]] = flit;
          end else begin
            defl = 1'b1;
          end
          if (defl) begin
            port        = lowest_free(taken);
            taken[port] = 1'b1;
            w_out[port] = flit;
            w_defl      = w_defl + 3'd1;
          end
        end
      end
    end

    if (bus.inj_valid && (taken != 4'hF)) begin
      w_inj_ready = 1'b1;
      if (!bus.inj_flit[9] && !taken[bus.inj_flit[8:7]]) port = bus.inj_flit[8:7];
      else                                               port = lowest_free(taken);
      w_out[port] = bus.inj_flit;
    end
  end

  assign w_defl_sum = {1'b0, r_defl_cnt} + (CNT_W+1)'(w_defl);
  assign w_defl_cnt = w_defl_sum[CNT_W] ? {CNT_W{1'b1}} : w_defl_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_out[i] <= '0;
      r_ej_flit  <= '0;
      r_ej_valid <= 1'b0;
      r_defl_cnt <= '0;
      r_prio_ptr <= 2'd0;
    end else begin
      for (int i = 0; i < 4; i++) r_out[i] <= w_out[i];
      r_ej_flit  <= w_ej_flit;
      r_ej_valid <= w_ej_take;
      r_defl_cnt <= w_defl_cnt;
      if (w_any_valid) r_prio_ptr <= r_prio_ptr + 2'd1;
    end
  end

`ifdef GOLDEN_PRIO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_epoch_cnt <= '0;
      r_golden_id <= 7'd0;
    end else if (r_epoch_cnt == EpW'(EPOCH_LEN - 1)) begin
      r_epoch_cnt <= '0;
      r_golden_id <= r_golden_id + 7'd1;
    end else begin
      r_epoch_cnt <= r_epoch_cnt + EpW'(1);
    end
  end
`endif

  assign bus.inj_ready = w_inj_ready;
  assign bus.nxt       = r_out[0];
  assign bus.sxt       = r_out[1];
  assign bus.ext       = r_out[2];
  assign bus.wxt       = r_out[3];
  assign bus.ej_flit   = r_ej_flit;
  assign bus.ej_valid  = r_ej_valid;
  assign bus.defl_cnt  = r_defl_cnt;

endmodule

// File: tb/tb_minbd_port_allocator.sv
// Directed bench for minbd_port_allocator with a queue of expected registered outputs.
module tb_minbd_port_allocator;
  localparam int unsigned CntW = 4;
`ifdef GOLDEN_PRIO_EN
  localparam int unsigned EpochLen = 8;
`else
  localparam int unsigned EpochLen = 64;
`endif
  localparam logic [2:0] DN = 3'd0, DS = 3'd1, DE = 3'd2, DW = 3'd3, DL = 3'd4;
  localparam logic [10:0] Z = 11'h0;

  typedef struct {
    logic [10:0]     n, s, e, w, ej;
    logic            ejv;
    logic [CntW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt;
  exp_t q[$];
  string tq[$];

  minbd_port_allocator_if #(.FLIT_W(11), .CNT_W(CntW)) bus ();

  minbd_port_allocator #(.FLIT_W(11), .EPOCH_LEN(EpochLen), .CNT_W(CntW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] fl(input logic [2:0] d, input logic [6:0] id);
    return {1'b1, d, id};
  endfunction

  task automatic cmp(input string tag, input string fld, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s.%s got=%0h exp=%0h", tag, fld, got, want);
    end
  endtask

  task automatic drive(input logic [10:0] n, s, e, w, inj, input logic injv, ejr);
    @(negedge clk);
    bus.nty = n; bus.sty = s; bus.ety = e; bus.wty = w;
    bus.inj_flit = inj; bus.inj_valid = injv; bus.ej_ready = ejr;
  endtask

  task automatic expect_out(input string tag, input logic [10:0] n, s, e, w, ej,
                            input logic ejv, input int cnt);
    exp_t x;
    x.n = n; x.s = s; x.e = e; x.w = w; x.ej = ej; x.ejv = ejv; x.cnt = CntW'(cnt);
    q.push_back(x);
    tq.push_back(tag);
  endtask

  task automatic check_now();
    exp_t  x;
    string tag;
    if (q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard got=empty exp=entry");
      return;
    end
    x   = q.pop_front();
    tag = tq.pop_front();
    cmp(tag, "nxt", 32'(bus.nxt), 32'(x.n));
    cmp(tag, "sxt", 32'(bus.sxt), 32'(x.s));
    cmp(tag, "ext", 32'(bus.ext), 32'(x.e));
    cmp(tag, "wxt", 32'(bus.wxt), 32'(x.w));
    cmp(tag, "ej_flit", 32'(bus.ej_flit), 32'(x.ej));
    cmp(tag, "ej_valid", 32'(bus.ej_valid), 32'(x.ejv));
    cmp(tag, "defl_cnt", 32'(bus.defl_cnt), 32'(x.cnt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_now();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.nty = Z; bus.sty = Z; bus.ety = Z; bus.wty = Z;
    bus.inj_flit = Z; bus.inj_valid = 1'b0; bus.ej_ready = 1'b0;
    #1;
    expect_out("reset", Z, Z, Z, Z, Z, 1'b0, 0);
    check_now();
    @(negedge clk);
    rst_n = 1'b1;

    drive(fl(DE, 1), fl(DW, 2), Z, Z, Z, 1'b0, 1'b0);
    expect_out("no_conflict", Z, Z, fl(DE, 1), fl(DW, 2), Z, 1'b0, 0);
    step();

    // Pointer walks 1,2,3,0: east wins S at 1 and 2, north wins at 3 and 0.
    drive(fl(DS, 3), Z, fl(DS, 4), Z, Z, 1'b0, 1'b0);
    expect_out("conflict_p1", fl(DS, 3), fl(DS, 4), Z, Z, Z, 1'b0, 1);
    step();
    drive(fl(DS, 3), Z, fl(DS, 4), Z, Z, 1'b0, 1'b0);
    expect_out("conflict_p2", fl(DS, 3), fl(DS, 4), Z, Z, Z, 1'b0, 2);
    step();
    drive(fl(DS, 3), Z, fl(DS, 4), Z, Z, 1'b0, 1'b0);
    expect_out("conflict_p3", fl(DS, 4), fl(DS, 3), Z, Z, Z, 1'b0, 3);
    step();
    drive(fl(DS, 3), Z, fl(DS, 4), Z, Z, 1'b0, 1'b0);
    expect_out("conflict_p0", fl(DS, 4), fl(DS, 3), Z, Z, Z, 1'b0, 4);
    step();

    drive(Z, Z, Z, fl(DL, 9), Z, 1'b0, 1'b1);
    expect_out("eject", Z, Z, Z, Z, fl(DL, 9), 1'b1, 4);
    step();
    drive(Z, Z, Z, Z, Z, 1'b0, 1'b1);
    expect_out("eject_pulse", Z, Z, Z, Z, Z, 1'b0, 4);
    step();
    drive(Z, Z, Z, fl(DL, 9), Z, 1'b0, 1'b0);
    expect_out("eject_blocked", fl(DL, 9), Z, Z, Z, Z, 1'b0, 5);
    step();
    drive(Z, Z, Z, fl(3'd6, 10), Z, 1'b0, 1'b1);
    expect_out("dir6_local", Z, Z, Z, Z, fl(3'd6, 10), 1'b1, 5);
    step();
    drive(fl(DL, 11), fl(3'd7, 12), Z, Z, Z, 1'b0, 1'b1);
    expect_out("two_local", fl(3'd7, 12), Z, Z, Z, fl(DL, 11), 1'b1, 6);
    step();

    drive(fl(DN, 20), fl(DS, 21), fl(DE, 22), fl(DW, 23), fl(DN, 7), 1'b1, 1'b0);
    #1;
    cmp("inj_full", "inj_ready", 32'(bus.inj_ready), 32'd0);
    expect_out("inj_full", fl(DN, 20), fl(DS, 21), fl(DE, 22), fl(DW, 23), Z, 1'b0, 6);
    step();
    drive(fl(DN, 24), fl(DS, 25), fl(DE, 26), Z, fl(DN, 7), 1'b1, 1'b0);
    #1;
    cmp("inj_defl", "inj_ready", 32'(bus.inj_ready), 32'd1);
    expect_out("inj_defl", fl(DN, 24), fl(DS, 25), fl(DE, 26), fl(DN, 7), Z, 1'b0, 6);
    step();
    drive(fl(DS, 30), Z, Z, Z, fl(DW, 31), 1'b1, 1'b0);
    #1;
    cmp("inj_direct", "inj_ready", 32'(bus.inj_ready), 32'd1);
    expect_out("inj_direct", Z, fl(DS, 30), Z, fl(DW, 31), Z, 1'b0, 6);
    step();
    drive(fl(DN, 32), Z, Z, Z, fl(DS, 33), 1'b0, 1'b0);
    #1;
    cmp("inj_idle", "inj_ready", 32'(bus.inj_ready), 32'd0);
    expect_out("inj_idle", fl(DN, 32), Z, Z, Z, Z, 1'b0, 6);
    step();

    drive(fl(DE, 40), Z, Z, Z, Z, 1'b0, 1'b0);
    expect_out("pre_reset", Z, Z, fl(DE, 40), Z, Z, 1'b0, 6);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", Z, Z, Z, Z, Z, 1'b0, 0);
    check_now();
    @(negedge clk);
    rst_n = 1'b1;
    bus.nty = fl(DS, 3); bus.sty = Z; bus.ety = fl(DS, 4); bus.wty = Z;
    expect_out("post_reset_ptr0", fl(DS, 4), fl(DS, 3), Z, Z, Z, 1'b0, 1);
    step();

    exp_cnt = 1;
    for (int i = 0; i < 4; i++) begin
      drive(fl(DL, 50), fl(DL, 50), fl(DL, 50), fl(DL, 50), Z, 1'b0, 1'b0);
      exp_cnt = (exp_cnt + 4 > 15) ? 15 : exp_cnt + 4;
      expect_out("saturate", fl(DL, 50), fl(DL, 50), fl(DL, 50), fl(DL, 50), Z, 1'b0, exp_cnt);
      step();
    end
    drive(Z, Z, Z, Z, Z, 1'b0, 1'b0);
    expect_out("sat_hold", Z, Z, Z, Z, Z, 1'b0, 15);
    step();

`ifdef GOLDEN_PRIO_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    drive(fl(DS, 0), Z, Z, fl(DS, 1), Z, 1'b0, 1'b0);
    expect_out("golden", fl(DS, 0), fl(DS, 1), Z, Z, Z, 1'b0, 1);
    step();
`endif

    if (q.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_drain got=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end
endmodule
